// File: rtl/conf_master.sv
// CONF write-channel initiator: buffers host register writes in a small FIFO
// and issues them one at a time on the CONF channel with c_ready backpressure and a timeout.
module conf_master #(
    parameter int unsigned C_ADDR_WIDTH = 8,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    h_valid,
    output logic                    h_ready,
    input  logic [C_ADDR_WIDTH-1:0] h_addr,
    input  logic [C_DATA_WIDTH-1:0] h_data,
    output logic [C_ADDR_WIDTH-1:0] c_addr,
    output logic [C_DATA_WIDTH-1:0] c_data,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             wr_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PTRX_W = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [C_ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [C_DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [PTR_W:0]          r_wptr;
    logic [PTR_W:0]          r_rptr;
    logic [C_ADDR_WIDTH-1:0] r_c_addr;
    logic [C_DATA_WIDTH-1:0] r_c_data;
    logic [WAIT_W-1:0]       r_wait;
    logic                    r_done;
    logic                    r_err;
    logic [15:0]             r_wr_count;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_timeout;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign h_ready = rst_n & ~w_full;
    assign w_push  = h_valid & h_ready;

    assign c_valid  = (r_state == DRIVE);
    assign c_addr   = r_c_addr;
    assign c_data   = r_c_data;
    assign busy     = ~w_empty | c_valid;
    assign done     = r_done;
    assign err      = r_err;
    assign wr_count = r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retire on acceptance or timeout; refill immediately if another entry is queued.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = DRIVE;
                end
            end
            DRIVE: begin
                w_accept  = c_ready;
                w_timeout = ~c_ready && (r_wait == WAIT_W'(TIMEOUT - 1));
                if (w_accept || w_timeout) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr[PTR_W-1:0]] <= h_addr;
            r_mem_data[r_wptr[PTR_W-1:0]] <= h_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_c_addr   <= '0;
            r_c_data   <= '0;
            r_wait     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTRX_W'(1);
            end
            if (w_pop) begin
                r_c_addr <= r_mem_addr[r_rptr[PTR_W-1:0]];
                r_c_data <= r_mem_data[r_rptr[PTR_W-1:0]];
                r_rptr   <= r_rptr + PTRX_W'(1);
                r_wait   <= '0;
            end else if (r_state == DRIVE && !c_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            r_done <= w_accept;
            r_err  <= w_timeout;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_conf_master.sv
// Directed self-checking bench for conf_master with default parameters.
module tb_conf_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        h_valid;
    logic        h_ready;
    logic [7:0]  h_addr;
    logic [31:0] h_data;
    logic [7:0]  c_addr;
    logic [31:0] c_data;
    logic        c_valid;
    logic        c_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] wr_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cnt_done = 0;
    int unsigned cnt_err  = 0;

    conf_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_valid  (h_valid),
        .h_ready  (h_ready),
        .h_addr   (h_addr),
        .h_data   (h_data),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (done) cnt_done = cnt_done + 1;
        if (err)  cnt_err  = cnt_err + 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned d0, e0, n, miss;

    initial begin
        rst_n   = 1'b0;
        h_valid = 1'b0;
        h_addr  = '0;
        h_data  = '0;
        c_ready = 1'b0;
        tick();
        tick();
        check("rst_h_ready", 32'(h_ready), 32'd0);
        check("rst_c_valid", 32'(c_valid), 32'd0);
        check("rst_c_addr", 32'(c_addr), 32'd0);
        check("rst_c_data", c_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_h_ready", 32'(h_ready), 32'd1);

        // Single write with responder already ready
        c_ready = 1'b1;
        h_valid = 1'b1;
        h_addr  = 8'h12;
        h_data  = 32'hDEADBEEF;
        tick();
        h_valid = 1'b0;
        check("sw_valid_latency", 32'(c_valid), 32'd0);
        check("sw_busy_queued", 32'(busy), 32'd1);
        tick();
        check("sw_valid", 32'(c_valid), 32'd1);
        check("sw_addr", 32'(c_addr), 32'h12);
        check("sw_data", c_data, 32'hDEADBEEF);
        tick();
        check("sw_valid_drop", 32'(c_valid), 32'd0);
        check("sw_done", 32'(done), 32'd1);
        check("sw_wr_count", 32'(wr_count), 32'd1);
        check("sw_busy_fall", 32'(busy), 32'd0);
        tick();
        check("sw_done_pulse", 32'(done), 32'd0);

        // Backpressure: 5 stalled cycles then accept
        d0 = cnt_done; e0 = cnt_err;
        c_ready = 1'b0;
        h_valid = 1'b1;
        h_addr  = 8'h34;
        h_data  = 32'h11112222;
        tick();
        h_valid = 1'b0;
        tick();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (c_valid && c_addr == 8'h34 && c_data == 32'h11112222) n++;
            tick();
        end
        check("bp_stable_valid_6th", 32'(c_valid), 32'd1);
        if (c_valid) n++;
        c_ready = 1'b1;
        tick();
        check("bp_valid_cycles", n, 32'd6);
        check("bp_valid_drop", 32'(c_valid), 32'd0);
        check("bp_wr_count", 32'(wr_count), 32'd2);
        tick();
        check("bp_done_count", cnt_done - d0, 32'd1);
        check("bp_err_count", cnt_err - e0, 32'd0);

        // Burst into full FIFO, then drain back-to-back
        c_ready = 1'b0;
        h_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            h_addr = 8'(8'h40 + i);
            h_data = 32'hA000 + 32'(i);
            check($sformatf("burst_h_ready_%0d", i), 32'(h_ready), 32'd1);
            tick();
        end
        check("burst_full", 32'(h_ready), 32'd0);
        h_addr = 8'h45;
        h_data = 32'hA005;
        tick();
        check("burst_stall", 32'(h_ready), 32'd0);
        h_valid = 1'b0;
        d0 = cnt_done;
        c_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_valid_%0d", i), 32'(c_valid), 32'd1);
            check($sformatf("burst_addr_%0d", i), 32'(c_addr), 32'h40 + 32'(i));
            check($sformatf("burst_data_%0d", i), c_data, 32'hA000 + 32'(i));
            tick();
        end
        check("burst_end_valid", 32'(c_valid), 32'd0);
        check("burst_wr_count", 32'(wr_count), 32'd7);
        check("burst_h_ready", 32'(h_ready), 32'd1);
        tick();
        check("burst_done_count", cnt_done - d0, 32'd5);
        check("burst_busy", 32'(busy), 32'd0);

        // Timeout: two entries, never accepted
        d0 = cnt_done; e0 = cnt_err;
        c_ready = 1'b0;
        h_valid = 1'b1;
        h_addr = 8'h50; h_data = 32'h5050;
        tick();
        h_addr = 8'h51; h_data = 32'h5151;
        tick();
        h_valid = 1'b0;
        n = 0;
        while (c_valid && c_addr == 8'h50 && n < 40) begin
            n++;
            tick();
        end
        check("to_first_cycles", n, 32'd16);
        check("to_first_err", 32'(err), 32'd1);
        check("to_second_valid", 32'(c_valid), 32'd1);
        check("to_second_addr", 32'(c_addr), 32'h51);
        n = 0;
        while (c_valid && c_addr == 8'h51 && n < 40) begin
            n++;
            tick();
        end
        check("to_second_cycles", n, 32'd16);
        check("to_second_err", 32'(err), 32'd1);
        check("to_idle", 32'(c_valid), 32'd0);
        check("to_wr_count", 32'(wr_count), 32'd7);
        tick();
        check("to_err_count", cnt_err - e0, 32'd2);
        check("to_done_count", cnt_done - d0, 32'd0);
        check("to_busy", 32'(busy), 32'd0);

        // Reset during the 2nd DRIVE cycle with entries still queued
        d0 = cnt_done; e0 = cnt_err;
        h_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h_addr = 8'(8'h60 + i);
            h_data = 32'h6000 + 32'(i);
            tick();
        end
        h_valid = 1'b0;
        check("mr_in_drive", 32'(c_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mr_valid", 32'(c_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        check("mr_wr_count", 32'(wr_count), 32'd0);
        check("mr_h_ready_low", 32'(h_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mr_h_ready", 32'(h_ready), 32'd1);
        tick();
        tick();
        check("mr_stays_idle", 32'(c_valid), 32'd0);
        check("mr_no_pulses", (cnt_done - d0) + (cnt_err - e0), 32'd0);

        // Counter wrap: 65535 writes, then one more
        d0 = cnt_done; e0 = cnt_err;
        c_ready = 1'b1;
        h_valid = 1'b1;
        miss = 0;
        for (int i = 0; i < 65535; i++) begin
            h_addr = 8'(i);
            h_data = 32'(i);
            if (!h_ready) miss++;
            tick();
        end
        h_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("wrap_no_stall", miss, 32'd0);
        check("wrap_ffff", 32'(wr_count), 32'hFFFF);
        h_valid = 1'b1;
        h_addr = 8'hAA;
        h_data = 32'hCAFE;
        tick();
        h_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("wrap_zero", 32'(wr_count), 32'd0);
        check("wrap_done_count", cnt_done - d0, 32'd65536);
        check("wrap_err_count", cnt_err - e0, 32'd0);
        check("wrap_idle", 32'(c_valid), 32'd0);
        check("wrap_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
